sram_controller: RTL

- Multi-cycle replacement path for the single-cycle data memory in the MEM stage of the ARM pipeline.
- Accepts the MEM stage's 32-bit read/write request (same word addressing, base 1024) and serialises it onto an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states.
- Drives ready; the hazard/freeze logic stalls the pipeline while ready is low.

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_phase_timer.sv | 31 +++
 rtl/sram_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the multi-cycle SRAM data-memory path.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Half-word select appended to the word index to form the SRAM address
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing one half-word phase of WAIT_CYCLES+1 cycles.
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_last,
  output logic phase_first_n_minus_1
);

  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign phase_last = (cnt == '0);
  // True when the following cycle still lies within the first N-1 cycles of the phase
  assign phase_first_n_minus_1 = (cnt > CW'(1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage 32-bit data memory serialised onto a 16-bit async SRAM as two half-word phases.
// Optional one-entry last-read cache enabled by defining SRAM_LAST_READ_CACHE_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam int unsigned IDX_W = SRAM_ADDR_W - 1;

  state_t           state;
  logic             op_wr;
  logic             op_inr;
  logic [IDX_W-1:0] op_idx;
  logic [31:0]      op_wdata;
  logic [15:0]      lo_buf;

  logic [31:0]      word_full;
  logic [IDX_W-1:0] req_idx;
  logic             req_inr;
  logic             req;
  logic             hit;
  logic             load;
  logic             phase_last;
  logic             phase_first_n_minus_1;

  assign req       = rd_en | wr_en;
  assign word_full = (address - BASE_ADDR) >> 2;
  assign req_idx   = word_full[IDX_W-1:0];
  assign req_inr   = (address >= BASE_ADDR) && (word_full < (32'd1 << IDX_W));

`ifdef SRAM_LAST_READ_CACHE_EN
  logic             c_valid;
  logic [IDX_W-1:0] c_idx;
  logic [31:0]      c_data;

  assign hit = rd_en && !wr_en && req_inr && c_valid && (c_idx == req_idx);
`else
  assign hit = 1'b0;
`endif

  assign load  = ((state == IDLE) && req && !hit) || ((state == LO) && phase_last);
  assign ready = ((state == IDLE) && !req) || (state == DONE);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk                  (clk),
    .rst                  (rst),
    .load                 (load),
    .phase_last           (phase_last),
    .phase_first_n_minus_1(phase_first_n_minus_1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      read_data   <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      op_wr       <= 1'b0;
      op_inr      <= 1'b0;
      op_idx      <= '0;
      op_wdata    <= '0;
      lo_buf      <= '0;
`ifdef SRAM_LAST_READ_CACHE_EN
      c_valid     <= 1'b0;
      c_idx       <= '0;
      c_data      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr    <= wr_en;
            op_inr   <= req_inr;
            op_idx   <= req_idx;
            op_wdata <= write_data;
            if (hit) begin
`ifdef SRAM_LAST_READ_CACHE_EN
              read_data <= c_data;
`endif
              state <= DONE;
            end else begin
              state       <= LO;
              sram_addr   <= {req_idx, HALF_LO};
              sram_dq_out <= write_data[15:0];
              sram_we_n   <= !(wr_en && req_inr);
              sram_dq_oe  <= wr_en && req_inr;
              sram_oe_n   <= !(!wr_en && req_inr);
            end
          end
        end
        LO: begin
          if (phase_last) begin
            lo_buf      <= op_inr ? sram_dq_in : 16'h0000;
            state       <= HI;
            sram_addr   <= {op_idx, HALF_HI};
            sram_dq_out <= op_wdata[31:16];
            sram_we_n   <= !(op_wr && op_inr);
          end else begin
            // Strobes are registered, so shape the value for the next cycle
            sram_we_n <= !(op_wr && op_inr && phase_first_n_minus_1);
          end
        end
        HI: begin
          if (phase_last) begin
            if (!op_wr) begin
              read_data <= {(op_inr ? sram_dq_in : 16'h0000), lo_buf};
            end
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else begin
            sram_we_n <= !(op_wr && op_inr && phase_first_n_minus_1);
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef SRAM_LAST_READ_CACHE_EN
          if (op_wr) begin
            if (op_inr && c_valid && (c_idx == op_idx)) begin
              c_data <= op_wdata;
            end
          end else if (op_inr) begin
            c_valid <= 1'b1;
            c_idx   <= op_idx;
            c_data  <= read_data;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
